// File: rtl/pipelined_alu.sv
// pipelined_alu: handshaked ALU with single-cycle logic/arith ops and iterative
// unsigned multiply/divide sharing one shift register.
module pipelined_alu #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   m_q, result_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               hi_q, zero_q, ovf_q;
  logic [WIDTH-1:0]   sum, diff, alu_d, rem_nx, eng_res;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic               ovf_d, ge, is_mul, is_div;
  assign sum    = a + b;
  assign diff   = a - b;
  assign is_mul = aluop[3:1] == 3'b100;
  assign is_div = aluop[3:1] == 3'b101;
  always_comb begin
    alu_d = '0;
    ovf_d = 1'b0;
    case (aluop)
      4'b0000: begin
        alu_d = sum;
        ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin
        alu_d = diff;
        ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0010: alu_d = a & b;
      4'b0011: alu_d = a | b;
      4'b0100: alu_d = a ^ b;
      4'b0101: alu_d = WIDTH'(a < b);
      4'b0110: alu_d = WIDTH'($signed(a) < $signed(b));
      4'b0111: alu_d = ~(a | b);
      default: alu_d = '0;
    endcase
  end
  // acc holds {hi, lo} product while multiplying and {remainder, dividend/quotient} while dividing
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ge      = rem_sh >= {1'b0, m_q};
  assign rem_nx  = ge ? WIDTH'(rem_sh - {1'b0, m_q}) : rem_sh[WIDTH-1:0];
  assign acc_d   = (state_q == MUL) ? {mul_sum, acc_q[WIDTH-1:1]}
                                    : {rem_nx, acc_q[WIDTH-2:0], ge};
  assign eng_res = hi_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      hi_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          hi_q  <= aluop[0];
          m_q   <= is_mul ? a : b;
          acc_q <= {{WIDTH{1'b0}}, is_mul ? b : a};
          cnt_q <= CW'(WIDTH);
          state_q <= is_mul ? MUL : is_div ? DIV : DONE;
          if (!is_mul && !is_div) begin
            result_q <= alu_d;
            zero_q   <= alu_d == '0;
            ovf_q    <= ovf_d;
          end
        end
        MUL, DIV: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q <= eng_res;
            zero_q   <= eng_res == '0;
            ovf_q    <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu: directed checks of the handshaked ALU at WIDTH=32 plus an 8-bit instance.
module tb_pipelined_alu;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, out_ready = 0, in_ready, out_valid, zero, ovf;
  logic [31:0] a = 0, b = 0, result;
  logic [3:0]  aluop = 0;
  logic        v8 = 0, or8 = 0, ir8, ov8, z8, f8;
  logic [7:0]  a8 = 0, b8 = 0, res8;
  logic [3:0]  op8 = 0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pipelined_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .aluop(aluop), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .ovf(ovf));
  pipelined_alu #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .a(a8), .b(b8),
    .aluop(op8), .out_valid(f8), .out_ready(or8), .result(res8), .zero(z8), .ovf(ov8));

  // issue one op, wait (bounded) for its result, then consume it
  task automatic run(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                     output int lat, output logic [31:0] r, output logic zz, output logic oo,
                     output logic ir_seen);
    @(posedge clk); #1;
    in_valid = 1; aluop = op; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1; ir_seen = 0;
    while (!out_valid && lat < 200) begin
      ir_seen |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    r = result; zz = zero; oo = ovf;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset;
    logic seen;
    #12;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL reset_hs got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
    total++; if (result !== 32'd0 || zero !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL reset_out got r=%h z=%b o=%b want 0", result, zero, ovf); end
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    in_valid = 1; aluop = 4'b1010; a = 100; b = 7;
    @(posedge clk); #1; in_valid = 0;
    repeat (10) begin @(posedge clk); #1; end
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL div_busy got ir=%b ov=%b want ir=0 ov=0", in_ready, out_valid); end
    #2 rst_n = 0;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || ovf !== 1'b0)
      begin bad++; $display("FAIL reset_mid got ir=%b ov=%b r=%h z=%b o=%b want 1 0 0 0 0", in_ready, out_valid, result, zero, ovf); end
    @(posedge clk); #1; rst_n = 1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
    total++; if (seen !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL reset_abort got seen=%b ir=%b want 0 1", seen, in_ready); end
  endtask

  task automatic test_addsub;
    int l; logic [31:0] r; logic z, o, irs;
    run(4'b0000, 32'h7FFFFFFF, 32'd1, l, r, z, o, irs);
    total++; if (r !== 32'h80000000) begin bad++; $display("FAIL add_res got=%h want=80000000", r); end
    total++; if (o !== 1'b1 || z !== 1'b0) begin bad++; $display("FAIL add_flags got z=%b o=%b want z=0 o=1", z, o); end
    total++; if (l !== 1) begin bad++; $display("FAIL add_lat got=%0d want=1", l); end
    run(4'b0001, 32'd5, 32'd5, l, r, z, o, irs);
    total++; if (r !== 32'd0 || z !== 1'b1 || o !== 1'b0) begin bad++; $display("FAIL sub_eq got r=%h z=%b o=%b want 0 1 0", r, z, o); end
    run(4'b0001, 32'h80000000, 32'd1, l, r, z, o, irs);
    total++; if (r !== 32'h7FFFFFFF || o !== 1'b1) begin bad++; $display("FAIL sub_ovf got r=%h o=%b want 7fffffff 1", r, o); end
  endtask

  task automatic test_logic;
    int l; logic [31:0] r; logic z, o, irs;
    run(4'b0011, 32'hF0, 32'h0F, l, r, z, o, irs);
    total++; if (r !== 32'hFF) begin bad++; $display("FAIL or got=%h want=ff", r); end
    run(4'b0100, 32'hFF, 32'h0F, l, r, z, o, irs);
    total++; if (r !== 32'hF0) begin bad++; $display("FAIL xor got=%h want=f0", r); end
    run(4'b0111, 32'h0, 32'h0, l, r, z, o, irs);
    total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL nor got=%h want=ffffffff", r); end
    run(4'b1100, 32'h1234, 32'h5678, l, r, z, o, irs);
    total++; if (r !== 32'd0 || z !== 1'b1 || l !== 1) begin bad++; $display("FAIL rsvd got r=%h z=%b lat=%0d want 0 1 1", r, z, l); end
  endtask

  task automatic test_slt;
    int l; logic [31:0] r; logic z, o, irs;
    run(4'b0110, 32'hFFFFFFFF, 32'd1, l, r, z, o, irs);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL slt got=%h want=1", r); end
    run(4'b0101, 32'hFFFFFFFF, 32'd1, l, r, z, o, irs);
    total++; if (r !== 32'd0 || z !== 1'b1) begin bad++; $display("FAIL sltu got r=%h z=%b want 0 1", r, z); end
    @(posedge clk); #1;
    v8 = 1; op8 = 4'b0110; a8 = 8'h80; b8 = 8'h7F;
    @(posedge clk); #1; v8 = 0;
    total++; if (f8 !== 1'b1 || res8 !== 8'h01) begin bad++; $display("FAIL slt8 got v=%b r=%h want 1 01", f8, res8); end
    or8 = 1; @(posedge clk); #1; or8 = 0;
  endtask

  task automatic test_mul;
    int l; logic [31:0] r; logic z, o, irs;
    run(4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, l, r, z, o, irs);
    total++; if (r !== 32'hFFFFFFFE || o !== 1'b0) begin bad++; $display("FAIL mulhi got r=%h o=%b want fffffffe 0", r, o); end
    total++; if (l !== 33) begin bad++; $display("FAIL mul_lat got=%0d want=33", l); end
    total++; if (irs !== 1'b0) begin bad++; $display("FAIL mul_ready got in_ready_seen=%b want 0", irs); end
    run(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, l, r, z, o, irs);
    total++; if (r !== 32'h00000001) begin bad++; $display("FAIL mullo got=%h want=1", r); end
    run(4'b1000, 32'd12345, 32'd678, l, r, z, o, irs);
    total++; if (r !== 32'd8369910) begin bad++; $display("FAIL mullo2 got=%0d want=8369910", r); end
  endtask

  task automatic test_div;
    int l; logic [31:0] r; logic z, o, irs;
    run(4'b1010, 32'd100, 32'd7, l, r, z, o, irs);
    total++; if (r !== 32'd14 || l !== 33) begin bad++; $display("FAIL divu got r=%0d lat=%0d want 14 33", r, l); end
    run(4'b1011, 32'd100, 32'd7, l, r, z, o, irs);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL remu got=%0d want=2", r); end
    run(4'b1010, 32'd9, 32'd0, l, r, z, o, irs);
    total++; if (r !== 32'hFFFFFFFF || l !== 33) begin bad++; $display("FAIL div0 got r=%h lat=%0d want ffffffff 33", r, l); end
    run(4'b1011, 32'd9, 32'd0, l, r, z, o, irs);
    total++; if (r !== 32'd9) begin bad++; $display("FAIL rem0 got=%0d want=9", r); end
    run(4'b1011, 32'hFFFFFFFF, 32'h10, l, r, z, o, irs);
    total++; if (r !== 32'hF) begin bad++; $display("FAIL rem_big got=%h want=f", r); end
  endtask

  task automatic test_hold;
    @(posedge clk); #1;
    in_valid = 1; aluop = 4'b0010; a = 32'h0F0F0F0F; b = 32'hFFFFFFFF;
    @(posedge clk); #1; in_valid = 0;
    total++; if (out_valid !== 1'b1 || result !== 32'h0F0F0F0F) begin bad++; $display("FAIL and got v=%b r=%h want 1 0f0f0f0f", out_valid, result); end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; aluop = 4'b0000; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h0F0F0F0F || zero !== 1'b0)
        begin bad++; $display("FAIL hold%0d got v=%b ir=%b r=%h want 1 0 0f0f0f0f", i, out_valid, in_ready, result); end
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL release got v=%b ir=%b want 0 1", out_valid, in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL noqueue got v=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1; aluop = 4'b0000; a = 32'd1; b = 32'd2; out_ready = 1;
    repeat (8) begin
      @(posedge clk); #1;
      n += int'(out_valid);
      if (out_valid) begin
        total++; if (result !== 32'd3) begin bad++; $display("FAIL b2b_res got=%h want=3", result); end
      end
    end
    in_valid = 0; out_ready = 0;
    total++; if (n !== 4) begin bad++; $display("FAIL b2b_rate got=%0d want=4", n); end
  endtask

  initial begin
    test_reset;
    test_addsub;
    test_logic;
    test_slt;
    test_mul;
    test_div;
    test_hold;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
